pwm_ramp_scheduler: RTL and testbench



---
 rtl/pwm_ramp_scheduler.sv | 134 +++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_scheduler.sv
// Soft-start/soft-stop duty sequencer for a PWM core: ramps the applied duty toward an accepted
// target one step every (div+1) PWM periods, with a level-sensitive emergency stop.
module pwm_ramp_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     tgt_duty,
  input  logic [WIDTH-1:0]     step,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic                 period_end,
  input  logic                 estop,
  output logic [WIDTH-1:0]     duty_out,
  output logic                 duty_load,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StRampDown = 2'd2,
    StEstop    = 2'd3
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     duty_q;
  logic [WIDTH-1:0]     tgt_q;
  logic [WIDTH-1:0]     step_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 load_q;
  logic                 done_q;
  logic                 busy_q;

  logic                 accept;
  logic [WIDTH-1:0]     step_eff;
  logic [WIDTH:0]       up_sum;
  logic                 up_hit;
  logic [WIDTH-1:0]     down_gap;
  logic                 down_hit;

  assign tgt_ready = (state_q == StIdle) & enable & ~estop;
  assign accept    = tgt_valid & tgt_ready;
  assign step_eff  = (step == '0) ? WIDTH'(1) : step;

  // Extra sum bit keeps the up-step from wrapping past full scale.
  assign up_sum   = {1'b0, duty_q} + {1'b0, step_q};
  assign up_hit   = up_sum >= {1'b0, tgt_q};
  // Only meaningful in StRampDown, where duty_q > tgt_q always holds.
  assign down_gap = duty_q - tgt_q;
  assign down_hit = down_gap <= step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (estop) begin
        // Load strobe only on entry; duty is already zero while the stop is held.
        load_q  <= (state_q != StEstop);
        duty_q  <= '0;
        cnt_q   <= '0;
        state_q <= StEstop;
        busy_q  <= 1'b1;
      end else if (state_q == StEstop) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else if (enable) begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              tgt_q  <= tgt_duty;
              step_q <= step_eff;
              div_q  <= div;
              cnt_q  <= '0;
              if (tgt_duty > duty_q) begin
                state_q <= StRampUp;
                busy_q  <= 1'b1;
              end else if (tgt_duty < duty_q) begin
                state_q <= StRampDown;
                busy_q  <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          StRampUp, StRampDown: begin
            if (period_end) begin
              if (cnt_q == div_q) begin
                cnt_q  <= '0;
                load_q <= 1'b1;
                if ((state_q == StRampUp) ? up_hit : down_hit) begin
                  duty_q  <= tgt_q;
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else if (state_q == StRampUp) begin
                  duty_q <= up_sum[WIDTH-1:0];
                end else begin
                  duty_q <= duty_q - step_q;
                end
              end else begin
                cnt_q <= cnt_q + DIV_WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign duty_out  = duty_q;
  assign duty_load = load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Randomized and directed bench for pwm_ramp_scheduler against a step-list reference model.
module tb_pwm_ramp_scheduler;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [W-1:0]  tgt_duty;
  logic [W-1:0]  step;
  logic [DW-1:0] div;
  logic          tgt_valid;
  logic          tgt_ready;
  logic          period_end;
  logic          estop;
  logic [W-1:0]  duty_out;
  logic          duty_load;
  logic          busy;
  logic          done;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 up, 2 down, 3 estop. A ramp is a precomputed list of
  // duty values, one popped every (div+1) qualifying period ends.
  int m_mode;
  int m_duty;
  int m_per;
  int m_pcnt;
  int m_q[$];
  int exp_load;
  int exp_done;

  always #5 clk = ~clk;

  pwm_ramp_scheduler #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tgt_duty  (tgt_duty),
    .step      (step),
    .div       (div),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .period_end(period_end),
    .estop     (estop),
    .duty_out  (duty_out),
    .duty_load (duty_load),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_duty   = 0;
    m_per    = 1;
    m_pcnt   = 0;
    exp_load = 0;
    exp_done = 0;
    m_q.delete();
  endtask

  task automatic model_predict();
    int s;
    int v;
    int t;
    exp_load = 0;
    exp_done = 0;
    if (rst) begin
      model_reset();
    end else if (estop) begin
      if (m_mode != 3) exp_load = 1;
      m_duty = 0;
      m_mode = 3;
      m_q.delete();
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (!enable) begin
      // frozen
    end else if (m_mode == 0) begin
      if (tgt_valid) begin
        s = (step == 0) ? 1 : int'(step);
        t = int'(tgt_duty);
        v = m_duty;
        m_q.delete();
        while (v != t) begin
          if (t > v) v = (v + s > t) ? t : v + s;
          else       v = (v - s < t) ? t : v - s;
          m_q.push_back(v);
        end
        m_per  = int'(div) + 1;
        m_pcnt = 0;
        if (t > m_duty)      m_mode = 1;
        else if (t < m_duty) m_mode = 2;
        else                 exp_done = 1;
      end
    end else if (period_end) begin
      m_pcnt++;
      if (m_pcnt == m_per) begin
        m_pcnt   = 0;
        m_duty   = m_q.pop_front();
        exp_load = 1;
        if (m_q.size() == 0) begin
          exp_done = 1;
          m_mode   = 0;
        end
      end
    end
  endtask

  // Called with clk low and inputs already driven.
  task automatic step_cycle();
    #1;
    check_eq("tgt_ready", tgt_ready, (m_mode == 0 && enable && !estop) ? 1 : 0);
    model_predict();
    @(posedge clk);
    #1;
    check_eq("duty_out", duty_out, m_duty);
    check_eq("duty_load", duty_load, exp_load);
    check_eq("done", done, exp_done);
    check_eq("state", state, m_mode);
    check_eq("busy", busy, (m_mode != 0) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int pe_every);
    for (int i = 0; i < n; i++) begin
      period_end = (pe_every > 0) && ((i % pe_every) == pe_every - 1);
      step_cycle();
    end
    period_end = 1'b0;
  endtask

  task automatic send(input int t, input int s, input int d);
    tgt_duty   = W'(t);
    step       = W'(s);
    div        = DW'(d);
    tgt_valid  = 1'b1;
    period_end = 1'b0;
    step_cycle();
    tgt_valid  = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic apply_reset_async();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_duty", duty_out, 0);
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_load", duty_load, 0);
    check_eq("async_rst_done", done, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    step_cycle();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    estop      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_duty   = '0;
    step       = '0;
    div        = '0;
    period_end = 1'b0;
    @(negedge clk);
    step_cycle();
    rst = 1'b0;
    step_cycle();

    // Reset mid-ramp
    send(200, 64, 0);
    run(15, 10);
    apply_reset_async();
    #1;
    check_eq("ready_after_rst", tgt_ready, 1);

    // Ramp up 64,128,192,200
    send(200, 64, 0);
    run(45, 10);
    check_eq("ramp_up_final", duty_out, 200);

    // Ramp down with div 2: 100, 10
    send(10, 100, 2);
    run(65, 10);
    check_eq("ramp_down_final", duty_out, 10);

    // Saturating up-step near full scale
    send(250, 255, 0);
    run(12, 10);
    send(255, 20, 0);
    run(12, 10);
    check_eq("no_wrap_final", duty_out, 255);

    // Equal target, then step=0 treated as 1
    send(10, 255, 0);
    run(12, 10);
    send(10, 5, 3);
    run(2, 0);
    send(13, 0, 0);
    run(35, 10);
    check_eq("unit_step_final", duty_out, 13);

    // Estop mid-ramp with a simultaneous target offer
    send(100, 5, 0);
    run(22, 10);
    estop     = 1'b1;
    tgt_valid = 1'b1;
    tgt_duty  = 8'd200;
    run(5, 2);
    check_eq("estop_duty", duty_out, 0);
    check_eq("estop_state", state, 3);
    estop     = 1'b0;
    tgt_valid = 1'b0;
    step_cycle();
    check_eq("estop_release_state", state, 0);
    #1;
    check_eq("estop_release_ready", tgt_ready, 1);

    // Enable low freezes the ramp for three period ends
    send(60, 10, 0);
    run(8, 4);
    enable = 1'b0;
    run(12, 4);
    check_eq("frozen_duty", duty_out, 20);
    enable = 1'b1;
    run(20, 4);
    check_eq("resume_final", duty_out, 60);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        apply_reset_async();
      end
      enable     = ($urandom_range(0, 15) != 0);
      estop      = ($urandom_range(0, 63) == 0);
      tgt_valid  = ($urandom_range(0, 3) == 0);
      tgt_duty   = W'($urandom);
      step       = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
      div        = DW'($urandom_range(0, 3));
      period_end = ($urandom_range(0, 2) == 0);
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
